// File: rtl/serial_adder.sv
// Multi-cycle adder: adds two WIDTH-bit operands plus carry-in one BITS_PER_CYCLE slice per clock.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic [BITS_PER_CYCLE:0] slice_add(
        input logic [BITS_PER_CYCLE-1:0] x,
        input logic [BITS_PER_CYCLE-1:0] y,
        input logic                      c
    );
        return {1'b0, x} + {1'b0, y} + {{BITS_PER_CYCLE{1'b0}}, c};
    endfunction

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]    psum_q, psum_d;
    logic                carry_q, carry_d;
    logic [WIDTH-1:0]    sum_q, sum_d;
    logic                cout_q, cout_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [BITS_PER_CYCLE:0] slice_s;
    logic [WIDTH-1:0]    psum_next_s;
`ifdef SERIAL_ADDER_OVF_EN
    // Operand sign bits are kept aside because the shift registers lose them.
    logic                a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic                ovf_q, ovf_d;
`endif

    // Slice adder and the partial sum with the new slice shifted in at the MSB end.
    always_comb begin
        slice_s     = slice_add(a_q[BITS_PER_CYCLE-1:0], b_q[BITS_PER_CYCLE-1:0], carry_q);
        psum_next_s = (psum_q >> BITS_PER_CYCLE)
                    | (WIDTH'(slice_s[BITS_PER_CYCLE-1:0]) << (WIDTH - BITS_PER_CYCLE));
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = {CW{1'b0}};
                    state_d = S_RUN;
`ifdef SERIAL_ADDER_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d     = a_q >> BITS_PER_CYCLE;
                b_d     = b_q >> BITS_PER_CYCLE;
                psum_d  = psum_next_s;
                carry_d = slice_s[BITS_PER_CYCLE];
                cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CW'(N - 1)) begin
                    sum_d   = psum_next_s;
                    cout_d  = slice_s[BITS_PER_CYCLE];
                    state_d = S_DONE;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = (a_msb_q == b_msb_q) && (psum_next_s[WIDTH-1] != a_msb_q);
`endif
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            psum_q  <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed and exhaustive bench for serial_adder across four WIDTH/BITS_PER_CYCLE configurations.
// Index 0: 8/1, 1: 8/2, 2: 4/4, 3: 4/1.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start_v [4];
    logic [7:0] a_v     [4];
    logic [7:0] b_v     [4];
    logic       cin_v   [4];
    logic       busy_v  [4];
    logic       done_v  [4];
    logic       cout_v  [4];
    logic       ovf_v   [4];
    logic [7:0] sum_v   [4];
    logic [3:0] sum4_2, sum4_3;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_8_1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf_v[0]),
`endif
        .cout(cout_v[0]));

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(2)) u_8_2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf_v[1]),
`endif
        .cout(cout_v[1]));

    serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(4)) u_4_4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2][3:0]), .b(b_v[2][3:0]), .cin(cin_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum4_2),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf_v[2]),
`endif
        .cout(cout_v[2]));

    serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(1)) u_4_1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .a(a_v[3][3:0]), .b(b_v[3][3:0]), .cin(cin_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .sum(sum4_3),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf_v[3]),
`endif
        .cout(cout_v[3]));

    assign sum_v[2] = {4'h0, sum4_2};
    assign sum_v[3] = {4'h0, sum4_3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One transaction; caller sits #1 after a posedge. Returns latency in edges after the start edge.
    task automatic run_op(input int d, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                          input int budget, output int lat, output int nbusy, output logic hold_ok,
                          output logic [7:0] s, output logic co);
        logic [7:0] prev;
        prev    = sum_v[d];
        hold_ok = 1'b1;
        a_v[d] = av; b_v[d] = bv; cin_v[d] = cv; start_v[d] = 1'b1;
        @(posedge clk); #1;
        start_v[d] = 1'b0;
        a_v[d] = ~av; b_v[d] = ~bv; cin_v[d] = ~cv;
        lat   = 0;
        nbusy = busy_v[d] ? 1 : 0;
        for (int j = 1; j <= budget; j++) begin
            @(posedge clk); #1;
            if (done_v[d]) begin
                lat = j;
                break;
            end
            if (busy_v[d]) nbusy++;
            if (sum_v[d] !== prev) hold_ok = 1'b0;
        end
        s  = sum_v[d];
        co = cout_v[d];
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int         lat, nbusy, ltmp;
        logic       hold_ok, co;
        logic [7:0] s;
        logic [4:0] exp5;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0, 1'b0};

        for (int d = 0; d < 4; d++) begin
            start_v[d] = 1'b0; a_v[d] = 8'h00; b_v[d] = 8'h00; cin_v[d] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy_v[0]}, 32'd0);
        chk("reset_done", {31'd0, done_v[0]}, 32'd0);
        chk("reset_sum",  {24'd0, sum_v[0]}, 32'd0);
        chk("reset_cout", {31'd0, cout_v[0]}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero operands: latency and busy width.
        run_op(0, 8'h00, 8'h00, 1'b0, 12, lat, nbusy, hold_ok, s, co);
        chk("zero_lat",   lat, 32'd8);
        chk("zero_busy",  nbusy, 32'd8);
        chk("zero_sum",   {24'd0, s}, 32'd0);
        chk("zero_cout",  {31'd0, co}, 32'd0);
        chk("zero_donelen", 32'(done_v[0]), 32'd1);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done_v[0]), 32'd0);

        // Table vectors, back to back; sum must hold the previous result while running.
        for (int i = 0; i < 8; i++) begin
            run_op(0, vecs[i].a, vecs[i].b, vecs[i].cin, 12, lat, nbusy, hold_ok, s, co);
            chk($sformatf("vec%0d_lat", i),  lat, 32'd8);
            chk($sformatf("vec%0d_sum", i),  {24'd0, s}, {24'd0, vecs[i].sum});
            chk($sformatf("vec%0d_cout", i), {31'd0, co}, {31'd0, vecs[i].cout});
            chk($sformatf("vec%0d_hold", i), {31'd0, hold_ok}, 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
            chk($sformatf("vec%0d_ovf", i),  {31'd0, ovf_v[0]}, {31'd0, vecs[i].ovf});
`endif
        end
        @(posedge clk); #1;

        // start during RUN is ignored; start held high restarts from the DONE cycle.
        a_v[0] = 8'h12; b_v[0] = 8'h34; cin_v[0] = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a_v[0] = 8'hFF; b_v[0] = 8'hFF; start_v[0] = 1'b1;
        @(posedge clk); #1;
        a_v[0] = 8'h01; b_v[0] = 8'h02;
        lat = 0;
        for (int j = 4; j <= 12; j++) begin
            @(posedge clk); #1;
            if (done_v[0]) begin lat = j; break; end
        end
        chk("ignore_lat", lat, 32'd8);
        chk("ignore_sum", {24'd0, sum_v[0]}, 32'h46);
        ltmp = 0;
        for (int j = 1; j <= 12; j++) begin
            @(posedge clk); #1;
            if (done_v[0]) begin ltmp = j; break; end
        end
        chk("hold_start_gap", ltmp, 32'd9);
        chk("hold_start_sum", {24'd0, sum_v[0]}, 32'h03);
        start_v[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Mid-operation asynchronous reset on the 2-bit-slice instance.
        run_op(1, 8'h0F, 8'h01, 1'b0, 8, lat, nbusy, hold_ok, s, co);
        chk("bpc2_pre_sum", {24'd0, s}, 32'h10);
        chk("bpc2_pre_lat", lat, 32'd4);
        a_v[1] = 8'h55; b_v[1] = 8'h55; cin_v[1] = 1'b0; start_v[1] = 1'b1;
        @(posedge clk); #1;
        start_v[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, busy_v[1]}, 32'd0);
        chk("rst_mid_done", {31'd0, done_v[1]}, 32'd0);
        chk("rst_mid_sum",  {24'd0, sum_v[1]}, 32'd0);
        chk("rst_mid_cout", {31'd0, cout_v[1]}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ltmp = 0;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            if (done_v[1] || busy_v[1]) ltmp++;
        end
        chk("rst_no_done", ltmp, 32'd0);
        run_op(1, 8'h55, 8'h55, 1'b0, 8, lat, nbusy, hold_ok, s, co);
        chk("bpc2_lat",  lat, 32'd4);
        chk("bpc2_sum",  {24'd0, s}, 32'hAA);
        chk("bpc2_cout", {31'd0, co}, 32'd0);
        @(posedge clk); #1;

        // Exhaustive 4-bit checks for N=1 and N=4.
        for (int d = 2; d < 4; d++) begin
            for (int v = 0; v < 512; v++) begin
                logic [3:0] av, bv;
                logic       cv;
                av   = v[3:0];
                bv   = v[7:4];
                cv   = v[8];
                exp5 = {1'b0, av} + {1'b0, bv} + {4'd0, cv};
                run_op(d, {4'h0, av}, {4'h0, bv}, cv, 8, lat, nbusy, hold_ok, s, co);
                chk($sformatf("ex%0d_%0d_res", d, v), {27'd0, co, s[3:0]}, {27'd0, exp5});
                chk($sformatf("ex%0d_%0d_lat", d, v), lat, (d == 2) ? 32'd1 : 32'd4);
            end
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Multi-cycle, parametrised adder for operands wider than one full-adder cell.
- Adds two WIDTH-bit operands plus carry-in by processing BITS_PER_CYCLE-bit slices, LSB slice first, through one shared slice adder with a registered carry.
- Sits between operand registers and a result consumer.
- Uses a start/busy/done handshake so area can be traded for latency.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be >= 1.
- BITS_PER_CYCLE, 1, slice width added per clock; must divide WIDTH exactly; N = WIDTH/BITS_PER_CYCLE slices.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active low.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while slices are being added.
- done  output  1  one-cycle pulse; sum/cout valid.
- sum  output  WIDTH  result; updates only on completion.
- cout  output  1  carry-out of MSB slice.
- ovf  output  1  signed overflow (present only with the optional feature).

Behaviour:
- Reset: rst_n low forces state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, slice counter=0, internal carry=0. Reset is asynchronous and takes effect immediately, including mid-operation. The partial result is discarded and no done is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: capture a, b and cin into internal shift registers, clear the slice counter, go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - busy=1.
  - Each edge adds the low BITS_PER_CYCLE bits of the A and B shift registers plus the carry register.
  - The slice sum is shifted into the MSB end of the partial-sum register; A and B shift right by BITS_PER_CYCLE.
  - The carry register takes the slice carry-out, and the counter increments.
  - On the edge that processes slice N-1: copy the partial sum to sum and the final carry to cout, then go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Next edge: if start=1, accept new operands (as in IDLE) and go to RUN; otherwise go to IDLE.
- Latency: start sampled at edge 0 -> RUN during edges 1..N -> done high in the cycle following edge N.
- Throughput: one result per N+1 cycles when start is held high.
- start while busy=1 is ignored. a/b/cin may change freely during RUN without affecting the result.
- sum, cout and ovf hold their last completed value in IDLE, RUN and DONE until the next completion. They are never partially updated.
- Arithmetic is unsigned modulo 2^WIDTH: {cout,sum} = a + b + cin.
- BITS_PER_CYCLE = WIDTH is legal: N=1, done occurs one cycle after start.
- Counter width is clog2(N), minimum 1 bit. Wrap-around of the counter is never reached because the state leaves RUN at N-1.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - ovf port exists.
  - On completion ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]), using the captured operands and the final sum. This is two's-complement overflow.
  - ovf is registered alongside sum, resets to 0 and is held like sum.
- Undefined:
  - ovf port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- WIDTH=8, BPC=1; after reset, start with a=8'h00, b=8'h00, cin=0 -> done pulses exactly 8 cycles after start is sampled, sum=8'h00, cout=0; busy high for those 8 cycles.
- WIDTH=8, BPC=1; a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1. sum must hold 8'h00 throughout the second RUN.
- WIDTH=8, BPC=1, SERIAL_ADDER_OVF_EN defined:
  - a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1.
  - a=8'h80, b=8'hFF -> sum=8'h7F, cout=1, ovf=1.
  - a=8'h10, b=8'h20 -> ovf=0.
- WIDTH=8, BPC=1; start a=8'h12, b=8'h34; pulse start with a=8'hFF, b=8'hFF at cycle 3 of RUN -> ignored, result sum=8'h46. Hold start high -> second add begins in the DONE cycle, next done exactly 9 cycles after the first.
- WIDTH=8, BPC=2; start a=8'h55, b=8'h55; drive rst_n low at cycle 2 of RUN -> busy=0, done never pulses, sum=0, cout=0 immediately. After release, a=8'h55+b=8'h55 -> sum=8'hAA, cout=0 with done 4 cycles after start.
- WIDTH=4, BPC=4 and WIDTH=4, BPC=1; exhaustively run all 512 combinations of a, b and cin -> {cout,sum} equals a+b+cin every time. Latency is 1 and 4 cycles respectively.
